// File: rtl/ifm_load_ctrl_pkg.sv
// Shared definitions for IFM row-buffer bank controllers: state encoding,
// element width and row-index sizing.
package ifm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int IFM_DATA_W = 8;

  // A single-row bank still needs a one-bit index.
  function automatic int row_idx_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/ifm_load_ctrl_if.sv
// Source stream plus row-buffer bank signals seen by the IFM load controller.
interface ifm_load_ctrl_if
  import ifm_ctrl_pkg::*;
#(
  parameter int COL  = 8,
  parameter int ROWS = 4
);
  logic                      src_valid;
  logic [COL*IFM_DATA_W-1:0] src_data;
  logic                      src_ready;
  logic [COL*IFM_DATA_W-1:0] ifm_in;
  logic [ROWS-1:0]           ifm_read;
  logic                      grp_full;
  logic                      grp_release;

  modport master (
    input  src_valid, src_data, grp_release,
    output src_ready, ifm_in, ifm_read, grp_full
  );

  modport slave (
    output src_valid, src_data, grp_release,
    input  src_ready, ifm_in, ifm_read, grp_full
  );
endinterface

// File: rtl/ifm_row_dec.sv
// Binary row index plus fire qualifier to one-hot row-buffer load strobe.
module ifm_row_dec
  import ifm_ctrl_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int RW   = row_idx_w(ROWS)
) (
  input  logic [RW-1:0]   row_idx_i,
  input  logic            fire_i,
  output logic [ROWS-1:0] read_o
);
  always_comb begin
    read_o = '0;
    for (int r = 0; r < ROWS; r++) begin
      read_o[r] = fire_i && (row_idx_i == RW'(r));
    end
  end
endmodule

// File: rtl/ifm_load_ctrl.sv
// Loads ROWS row buffers per group from a valid/ready stream, holds the bank
// until released, repeats for num_groups. Optional IFM_LOAD_CTRL_PERF_EN adds stall_cycles.
module ifm_load_ctrl
  import ifm_ctrl_pkg::*;
#(
  parameter int COL    = 8,
  parameter int ROWS   = 4,
  parameter int TILE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] num_groups,
  ifm_load_ctrl_if.master   bus,
  output logic              busy,
`ifdef IFM_LOAD_CTRL_PERF_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              done
);
  localparam int RW = row_idx_w(ROWS);

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [TILE_W-1:0] grp_q, grp_d;
  logic [TILE_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              fire, last_row, last_grp, start_acc;

  assign fire      = (state_q == LOAD) && bus.src_valid;
  assign last_row  = (row_q == RW'(ROWS - 1));
  // cnt_q is never 0 outside IDLE, so cnt_q-1 cannot wrap here.
  assign last_grp  = (grp_q == (cnt_q - TILE_W'(1)));
  assign start_acc = (state_q == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      grp_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      grp_q   <= grp_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    grp_d   = grp_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = num_groups;
          row_d = '0;
          grp_d = '0;
          if (num_groups != '0) state_d = LOAD;
          else                  done_d  = 1'b1;
        end
      end
      LOAD: begin
        if (fire) begin
          if (last_row) begin
            row_d   = '0;
            state_d = HOLD;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      HOLD: begin
        if (bus.grp_release) begin
          if (last_grp) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            grp_d   = grp_q + TILE_W'(1);
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  ifm_row_dec #(.ROWS(ROWS), .RW(RW)) u_row_dec (
    .row_idx_i (row_q),
    .fire_i    (fire),
    .read_o    (bus.ifm_read)
  );

  assign bus.src_ready = (state_q == LOAD);
  assign bus.grp_full  = (state_q == HOLD);
  assign bus.ifm_in    = bus.src_data;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

`ifdef IFM_LOAD_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if ((state_q == LOAD) && !bus.src_valid && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif
endmodule

// File: tb/tb_ifm_load_ctrl.sv
// Bench for ifm_load_ctrl: cycle table, reset/short-bank sequences and a
// randomized run against a count-based reference model.
module tb_ifm_load_ctrl;
  import ifm_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance: ROWS=4, TILE_W=16
  logic        start;
  logic [15:0] num_groups;
  logic        busy, done;
  ifm_load_ctrl_if #(.COL(8), .ROWS(4)) bus ();
`ifdef IFM_LOAD_CTRL_PERF_EN
  logic [31:0] stall_cycles;
`endif

  ifm_load_ctrl #(.COL(8), .ROWS(4), .TILE_W(16)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_groups   (num_groups),
    .bus          (bus.master),
    .busy         (busy),
`ifdef IFM_LOAD_CTRL_PERF_EN
    .stall_cycles (stall_cycles),
`endif
    .done         (done)
  );

  // Small instance: ROWS=2, TILE_W=2
  logic       start2;
  logic [1:0] num_groups2;
  logic       busy2, done2;
  ifm_load_ctrl_if #(.COL(8), .ROWS(2)) bus2 ();
`ifdef IFM_LOAD_CTRL_PERF_EN
  logic [31:0] stall_cycles2;
`endif

  ifm_load_ctrl #(.COL(8), .ROWS(2), .TILE_W(2)) u_dut2 (
    .clk          (clk),
    .rst          (rst),
    .start        (start2),
    .num_groups   (num_groups2),
    .bus          (bus2.master),
    .busy         (busy2),
`ifdef IFM_LOAD_CTRL_PERF_EN
    .stall_cycles (stall_cycles2),
`endif
    .done         (done2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] obs1();
    return {bus.src_ready, bus.ifm_read, bus.grp_full, busy, done};
  endfunction

  function automatic logic [5:0] obs2();
    return {bus2.src_ready, bus2.ifm_read, bus2.grp_full, busy2, done2};
  endfunction

  // Apply inputs at the falling edge, leave 1 ns before the rising edge for checks.
  task automatic drive(input logic st, input logic [15:0] ng, input logic v, input logic rl);
    @(negedge clk);
    start           = st;
    num_groups      = ng;
    bus.src_valid   = v;
    bus.grp_release = rl;
    bus.src_data    = {$urandom, $urandom};
    #4;
  endtask

  typedef struct {
    logic        st;
    logic [15:0] ng;
    logic        v;
    logic        rl;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, input logic [15:0] ng, input logic v, input logic rl,
                     input logic rdy, input logic [3:0] rd, input logic full,
                     input logic bsy, input logic dn);
    vec_t e;
    e.st = st; e.ng = ng; e.v = v; e.rl = rl;
    e.exp = {rdy, rd, full, bsy, dn};
    tbl.push_back(e);
  endtask

  // Reference model state (counts, not states)
  bit          m_active;
  int          m_rows, m_grp, m_total;
  bit          m_done;
  longint      m_stall;

  initial begin
    start = 0; num_groups = 0;
    bus.src_valid = 0; bus.src_data = '0; bus.grp_release = 0;
    start2 = 0; num_groups2 = 0;
    bus2.src_valid = 0; bus2.src_data = '0; bus2.grp_release = 0;

    repeat (2) @(negedge clk);
    #4;
    chk("reset_outputs", obs1(), 8'h00);
    chk("reset_outputs2", obs2(), 6'h00);
    @(negedge clk);
    rst = 1'b0;

    // Two groups with valid high, ignored start/release, then empty start, then valid gaps
    add(1,2,0,0, 0,4'b0000,0,0,0);
    add(0,0,1,0, 1,4'b0001,0,1,0);
    add(0,0,1,0, 1,4'b0010,0,1,0);
    add(0,0,1,0, 1,4'b0100,0,1,0);
    add(0,0,1,0, 1,4'b1000,0,1,0);
    add(0,0,1,0, 0,4'b0000,1,1,0);
    add(0,0,1,0, 0,4'b0000,1,1,0);
    add(0,0,0,1, 0,4'b0000,1,1,0);
    add(0,0,1,0, 1,4'b0001,0,1,0);
    add(1,5,1,0, 1,4'b0010,0,1,0);
    add(0,0,1,1, 1,4'b0100,0,1,0);
    add(0,0,0,0, 1,4'b0000,0,1,0);
    add(0,0,1,0, 1,4'b1000,0,1,0);
    add(0,0,0,0, 0,4'b0000,1,1,0);
    add(0,0,0,0, 0,4'b0000,1,1,0);
    add(0,0,0,1, 0,4'b0000,1,1,0);
    add(0,0,0,0, 0,4'b0000,0,0,1);
    add(0,0,0,1, 0,4'b0000,0,0,0);
    add(1,0,1,0, 0,4'b0000,0,0,0);
    add(0,0,1,0, 0,4'b0000,0,0,1);
    add(0,0,0,0, 0,4'b0000,0,0,0);
    add(1,1,0,0, 0,4'b0000,0,0,0);
    add(0,0,1,0, 1,4'b0001,0,1,0);
    add(0,0,0,0, 1,4'b0000,0,1,0);
    add(0,0,0,0, 1,4'b0000,0,1,0);
    add(0,0,1,0, 1,4'b0010,0,1,0);
    add(0,0,1,0, 1,4'b0100,0,1,0);
    add(0,0,0,0, 1,4'b0000,0,1,0);
    add(0,0,1,0, 1,4'b1000,0,1,0);
    add(0,0,0,1, 0,4'b0000,1,1,0);
    add(0,0,0,0, 0,4'b0000,0,0,1);

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].ng, tbl[i].v, tbl[i].rl);
      chk($sformatf("table[%0d]", i), obs1(), tbl[i].exp);
      chk($sformatf("table_pass[%0d]", i), bus.ifm_in, bus.src_data);
    end
`ifdef IFM_LOAD_CTRL_PERF_EN
    chk("stall_cycles_toggle", stall_cycles, 32'd3);
`endif

    // Asynchronous reset after two rows of the first group
    drive(1, 1, 0, 0);
    drive(0, 0, 1, 0);
    chk("pre_rst_row0", obs1(), {1'b1, 4'b0001, 3'b010});
    drive(0, 0, 1, 0);
    chk("pre_rst_row1", obs1(), {1'b1, 4'b0010, 3'b010});
    @(negedge clk);
    bus.src_valid = 1'b1;
    #2;
    chk("pre_rst_row2", obs1(), {1'b1, 4'b0100, 3'b010});
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", obs1(), 8'h00);
`ifdef IFM_LOAD_CTRL_PERF_EN
    chk("async_rst_stall", stall_cycles, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    bus.src_valid = 1'b0;
    #4;
    chk("post_rst_idle", obs1(), 8'h00);
    drive(1, 1, 0, 0);
    for (int r = 0; r < 4; r++) begin
      drive(0, 0, 1, 0);
      chk($sformatf("restart_row%0d", r), obs1(), {1'b1, 4'(1 << r), 3'b010});
    end
    drive(0, 0, 0, 1);
    chk("restart_hold", obs1(), {1'b0, 4'b0000, 3'b110});
    drive(0, 0, 0, 0);
    chk("restart_done", obs1(), 8'h01);

    // Short bank, narrow count: three groups with immediate release
    @(negedge clk);
    start2 = 1'b1; num_groups2 = 2'd3; bus2.src_valid = 1'b1; bus2.grp_release = 1'b1;
    #4;
    chk("r2_start", obs2(), 6'h00);
    @(negedge clk);
    start2 = 1'b0; num_groups2 = 2'd0;
    for (int g = 0; g < 3; g++) begin
      for (int r = 0; r < 2; r++) begin
        #4;
        chk($sformatf("r2_g%0d_row%0d", g, r), obs2(), {1'b1, 2'(1 << r), 3'b010});
        @(negedge clk);
      end
      #4;
      chk($sformatf("r2_g%0d_hold", g), obs2(), {1'b0, 2'b00, 3'b110});
      @(negedge clk);
    end
    #4;
    chk("r2_done", obs2(), 6'h01);
    @(negedge clk);
    bus2.src_valid = 1'b0; bus2.grp_release = 1'b0;
    #4;
    chk("r2_idle_after", obs2(), 6'h00);

    // Randomized run against the count-based model
    m_active = 0; m_rows = 0; m_grp = 0; m_total = 0; m_done = 0; m_stall = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        st, v, rl;
      logic [15:0] ng;
      logic        e_rdy, e_full;
      logic [3:0]  e_rd;
      bit          nd;
      st = ($urandom_range(0, 7) == 0);
      ng = 16'($urandom_range(0, 3));
      v  = $urandom_range(0, 1);
      rl = ($urandom_range(0, 2) == 0);
      drive(st, ng, v, rl);

      e_rdy  = m_active && (m_rows < 4);
      e_full = m_active && (m_rows == 4);
      e_rd   = (e_rdy && v) ? 4'(1 << m_rows) : 4'b0000;
      chk($sformatf("rand[%0d]", c), obs1(), {e_rdy, e_rd, e_full, m_active, m_done});
      chk($sformatf("rand_pass[%0d]", c), bus.ifm_in, bus.src_data);
`ifdef IFM_LOAD_CTRL_PERF_EN
      chk($sformatf("rand_stall[%0d]", c), stall_cycles, 32'(m_stall));
`endif

      nd = 0;
      if (!m_active && st) begin
        m_total = int'(ng);
        m_stall = 0;
        if (ng == 0) nd = 1;
        else begin
          m_active = 1; m_rows = 0; m_grp = 0;
        end
      end else if (e_rdy) begin
        if (v) m_rows++;
        else if (m_stall < 64'hFFFF_FFFF) m_stall++;
      end else if (e_full && rl) begin
        m_grp++;
        m_rows = 0;
        if (m_grp == m_total) begin
          m_active = 0;
          nd = 1;
        end
      end
      m_done = nd;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
